// File: rtl/host_guess_checker.sv
// Host-side hangman engine: latches the secret word on a rec_ready rise,
// scans each ASCII guess one byte per cycle and tracks reveals/mistakes.
//
// Ports:
//   clk, nRst        clock, async active-low reset
//   rec_ready        word-final level from the message register
//   temp_word[39:0]  secret word, [39:32] is position 0
//   guess[7:0]       ASCII guess, qualified by guess_valid
//   disp_word[39:0]  revealed letters, 0x5F where hidden
//   mistakes[3:0]    wrong-guess count
//   guess_done       pulse per processed guess, guess_hit with it
//   win, lose        result levels while in END
//   busy             high in SCAN and UPDATE
//   gameEnd_host     pulse back to the message register
//
// Optional: define REPEAT_PENALTY_EN to count repeat guesses as misses.

module host_guess_checker #(
    parameter int MAX_MISTAKES = 6,
    parameter int END_HOLD     = 12_000_000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        rec_ready,
    input  logic [39:0] temp_word,
    input  logic [7:0]  guess,
    input  logic        guess_valid,
    output logic [39:0] disp_word,
    output logic [3:0]  mistakes,
    output logic        guess_done,
    output logic        guess_hit,
    output logic        win,
    output logic        lose,
    output logic        busy,
    output logic        gameEnd_host
);

    localparam int CW = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
    localparam logic [39:0] BLANK = 40'h5F5F5F5F5F;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SCAN, S_UPD, S_END
    } state_t;

    state_t state_q, state_d;

    logic          rr_q;
    logic [39:0]   word_q;
    logic [4:0]    reveal_q, match_q, load_mask, rev_upd, rev_add;
    logic [25:0]   used_q;
    logic [7:0]    guess_q, cur_byte;
    logic [2:0]    idx_q;
    logic          hit_q, rpt, miss, hit_out;
    logic [CW-1:0] cnt_q;
    logic [4:0]    gidx;
    logic [3:0]    mis_upd;
    logic          load, abort, guess_ok, win_cond;
    logic          done_d, ghit_d, win_d, lose_d;
    logic          busy_d, gend_d;

    function automatic logic [39:0] disp_of(
        input logic [39:0] w,
        input logic [4:0]  m
    );
        logic [39:0] r;
        for (int i = 0; i < 5; i++)
            r[8*(4-i) +: 8] = m[i] ? w[8*(4-i) +: 8] : 8'h5F;
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 5; i++)
            load_mask[i] = (temp_word[8*(4-i) +: 8] == 8'h5F);
    end

    always_comb begin
        case (idx_q)
            3'd0:    cur_byte = word_q[39:32];
            3'd1:    cur_byte = word_q[31:24];
            3'd2:    cur_byte = word_q[23:16];
            3'd3:    cur_byte = word_q[15:8];
            default: cur_byte = word_q[7:0];
        endcase
    end

    assign load     = rec_ready & ~rr_q;
    assign abort    = ~rec_ready;
    assign guess_ok = guess_valid & (guess >= 8'h41) & (guess <= 8'h5A);
    assign gidx     = 5'(guess_q - 8'h41);
    assign rpt      = used_q[gidx];

`ifdef REPEAT_PENALTY_EN
    assign miss    = ~hit_q | rpt;
    assign hit_out = hit_q & ~rpt;
`else
    assign miss    = ~hit_q & ~rpt;
    assign hit_out = hit_q;
`endif

    assign rev_add = (hit_q & ~rpt) ? match_q : 5'b0;
    assign rev_upd = reveal_q | rev_add;
    assign mis_upd = mistakes + {3'b0, miss};

    // state register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (load)
                    state_d = (&load_mask) ? S_END : S_WAIT;
            S_WAIT:
                if (abort)         state_d = S_IDLE;
                else if (guess_ok) state_d = S_SCAN;
            S_SCAN:
                if (abort)              state_d = S_IDLE;
                else if (idx_q == 3'd4) state_d = S_UPD;
            S_UPD:
                if (abort)         state_d = S_IDLE;
                else if (&rev_upd) state_d = S_END;
                else if (mis_upd == 4'(MAX_MISTAKES))
                    state_d = S_END;
                else               state_d = S_WAIT;
            S_END:
                if (cnt_q == CW'(END_HOLD - 1))
                    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // output logic (values registered below)
    always_comb begin
        win_cond = (state_q == S_IDLE) | (&rev_upd);
        done_d   = (state_q == S_UPD) & ~abort;
        ghit_d   = done_d & hit_out;
        busy_d   = (state_d == S_SCAN) | (state_d == S_UPD);
        gend_d   = (state_q == S_END) & (state_d == S_IDLE);
        win_d    = win;
        lose_d   = lose;
        if (state_d != S_END) begin
            win_d  = 1'b0;
            lose_d = 1'b0;
        end else if (state_q != S_END) begin
            win_d  = win_cond;
            lose_d = ~win_cond;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            guess_done   <= 1'b0;
            guess_hit    <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            busy         <= 1'b0;
            gameEnd_host <= 1'b0;
        end else begin
            guess_done   <= done_d;
            guess_hit    <= ghit_d;
            win          <= win_d;
            lose         <= lose_d;
            busy         <= busy_d;
            gameEnd_host <= gend_d;
        end
    end

    // datapath: word, masks, scan index, mistakes, hold counter
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rr_q      <= 1'b0;
            word_q    <= '0;
            reveal_q  <= '0;
            match_q   <= '0;
            used_q    <= '0;
            guess_q   <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            cnt_q     <= '0;
            mistakes  <= '0;
            disp_word <= BLANK;
        end else begin
            rr_q <= rec_ready;
            case (state_q)
                S_IDLE:
                    if (load) begin
                        word_q    <= temp_word;
                        reveal_q  <= load_mask;
                        used_q    <= '0;
                        mistakes  <= '0;
                        cnt_q     <= '0;
                        disp_word <= disp_of(temp_word, load_mask);
                    end
                S_WAIT, S_SCAN, S_UPD:
                    if (abort) begin
                        reveal_q  <= '0;
                        mistakes  <= '0;
                        disp_word <= BLANK;
                    end else if (state_q == S_WAIT) begin
                        if (guess_ok) begin
                            guess_q <= guess;
                            idx_q   <= '0;
                            hit_q   <= 1'b0;
                            match_q <= '0;
                        end
                    end else if (state_q == S_SCAN) begin
                        if (cur_byte == guess_q) begin
                            hit_q   <= 1'b1;
                            match_q <= match_q | (5'b1 << idx_q);
                        end
                        idx_q <= idx_q + 3'd1;
                    end else begin
                        used_q    <= used_q | (26'b1 << gidx);
                        reveal_q  <= rev_upd;
                        mistakes  <= mis_upd;
                        disp_word <= disp_of(word_q, rev_upd);
                        cnt_q     <= '0;
                    end
                S_END:
                    cnt_q <= cnt_q + CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_guess_checker.sv
// Self-checking bench for host_guess_checker: directed game scenarios
// plus random games against a letter-level hangman model.

module tb_host_guess_checker;

    logic        clk = 1'b0;
    logic        nRst;
    logic        rec_ready;
    logic [39:0] temp_word;
    logic [7:0]  guess;
    logic        guess_valid;
    logic [39:0] disp_word;
    logic [3:0]  mistakes;
    logic        guess_done, guess_hit, win, lose, busy, gameEnd_host;

    always #5 clk = ~clk;

    host_guess_checker #(.MAX_MISTAKES(6), .END_HOLD(4)) dut (
        .clk(clk), .nRst(nRst), .rec_ready(rec_ready),
        .temp_word(temp_word), .guess(guess),
        .guess_valid(guess_valid), .disp_word(disp_word),
        .mistakes(mistakes), .guess_done(guess_done),
        .guess_hit(guess_hit), .win(win), .lose(lose),
        .busy(busy), .gameEnd_host(gameEnd_host)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hangman model: letters, revealed flags, used letters, misses
    logic [7:0] mw[5];
    bit         mrev[5];
    bit         mused[26];
    int         mmis;
    bit         mwin, mlose;

    function automatic logic [39:0] mdisp();
        logic [39:0] r;
        for (int i = 0; i < 5; i++)
            r[39-8*i -: 8] = mrev[i] ? mw[i] : 8'h5F;
        return r;
    endfunction

    task automatic model_load(input logic [39:0] w);
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            mw[i]   = w[39-8*i -: 8];
            mrev[i] = (mw[i] == 8'h5F);
            if (mrev[i]) n++;
        end
        for (int i = 0; i < 26; i++) mused[i] = 0;
        mmis  = 0;
        mwin  = (n == 5);
        mlose = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) mrev[i] = 0;
        mmis = 0; mwin = 0; mlose = 0;
    endtask

    task automatic model_guess(input logic [7:0] g, output bit h);
        bit any = 0;
        bit rep;
        int n = 0;
        for (int i = 0; i < 5; i++) if (mw[i] == g) any = 1;
        rep = mused[g - 8'h41];
        h = any;
        if (rep) begin
`ifdef REPEAT_PENALTY_EN
            mmis++;
            h = 0;
`endif
        end else begin
            mused[g - 8'h41] = 1;
            if (any) begin
                for (int i = 0; i < 5; i++)
                    if (mw[i] == g) mrev[i] = 1;
            end else mmis++;
        end
        for (int i = 0; i < 5; i++) if (mrev[i]) n++;
        mwin  = (n == 5);
        mlose = !mwin && (mmis == 6);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_guess(input logic [7:0] g);
        int lat = 0;
        bit seen = 0;
        bit eh;
        guess = g;
        guess_valid = 1;
        tick();
        guess_valid = 0;
        guess = 8'($urandom);
        if (g < 8'h41 || g > 8'h5A) begin
            for (int k = 0; k < 8; k++) begin
                if (guess_done) seen = 1;
                tick();
            end
            check("invalid_no_done", seen, 0);
            check("invalid_mistakes", mistakes, mmis);
            return;
        end
        check("busy_scan", busy, 1);
        while (!guess_done && lat < 20) begin
            tick();
            lat++;
        end
        check("guess_latency", lat, 6);
        model_guess(g, eh);
        check("guess_hit", guess_hit, eh);
        check("disp_word", disp_word, mdisp());
        check("mistakes", mistakes, mmis);
        check("win", win, mwin);
        check("lose", lose, mlose);
    endtask

    task automatic end_handoff();
        int n = 0;
        bit saw = 0;
        logic [39:0] dexp;
        dexp = mdisp();
        guess = 8'h41;
        guess_valid = 1;
        while (!gameEnd_host && n < 20) begin
            tick();
            guess_valid = 0;
            if (guess_done) saw = 1;
            n++;
        end
        check("end_hold_cycles", n, 4);
        check("end_guess_ignored", saw, 0);
        check("end_mistakes_held", mistakes, mmis);
        check("win_cleared", win, 0);
        check("lose_cleared", lose, 0);
        tick();
        check("gameEnd_single", gameEnd_host, 0);
        repeat (3) tick();
        check("no_reload_disp", disp_word, dexp);
        check("no_reload_mis", mistakes, mmis);
        rec_ready = 0;
        tick();
    endtask

    task automatic start_game(input logic [39:0] w);
        rec_ready = 0;
        temp_word = w;
        tick();
        tick();
        rec_ready = 1;
        tick();
        model_load(w);
        check("load_disp", disp_word, mdisp());
        check("load_mistakes", mistakes, 0);
        check("load_win", win, mwin);
        check("load_busy", busy, 0);
        if (mwin) end_handoff();
    endtask

    initial begin
        logic [39:0] w;
        logic [7:0]  g;
        bit          saw;
        nRst = 0;
        rec_ready = 0;
        temp_word = '0;
        guess = '0;
        guess_valid = 0;
        #12;
        check("rst_disp", disp_word, 40'h5F5F5F5F5F);
        check("rst_mistakes", mistakes, 0);
        check("rst_flags",
              {guess_done, guess_hit, win, lose, busy, gameEnd_host}, 0);
        @(negedge clk);
        nRst = 1;
        tick();

        // HELLO: multi-hit, miss, repeat, invalid, win
        start_game(40'h48454C4C4F);
        do_guess(8'h4C);
        check("multi_hit_disp", disp_word, 40'h5F5F4C4C5F);
        do_guess(8'h5A);
        check("miss_count", mistakes, 1);
        do_guess(8'h5A);
`ifdef REPEAT_PENALTY_EN
        check("repeat_count", mistakes, 2);
`else
        check("repeat_count", mistakes, 1);
`endif
        do_guess(8'h31);
        do_guess(8'h48);
        do_guess(8'h45);
        do_guess(8'h4F);
        check("win_level", win, 1);
        check("win_disp", disp_word, 40'h48454C4C4F);
        end_handoff();

        // loss with six distinct wrong letters
        start_game(40'h48454C4C4F);
        foreach (w[i]) if (i < 6) do_guess(8'h55 + 8'(i));
        check("lose_level", lose, 1);
        check("lose_mistakes", mistakes, 6);
        end_handoff();

        // partial word, then abort mid-scan
        start_game(40'h5F5F5F4142);
        check("partial_disp", disp_word, 40'h5F5F5F5F5F);
        do_guess(8'h5A);
        guess = 8'h41;
        guess_valid = 1;
        tick();
        guess_valid = 0;
        tick();
        rec_ready = 0;
        saw = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (guess_done || gameEnd_host) saw = 1;
        end
        model_clear();
        check("abort_quiet", saw, 0);
        check("abort_disp", disp_word, mdisp());
        check("abort_mistakes", mistakes, 0);
        check("abort_busy", busy, 0);

        // partial word won with two letters
        start_game(40'h5F5F5F4142);
        do_guess(8'h41);
        do_guess(8'h42);
        check("partial_win", win, 1);
        end_handoff();

        // random games
        for (int gm = 0; gm < 10; gm++) begin
            for (int i = 0; i < 5; i++)
                w[39-8*i -: 8] = ($urandom_range(7) == 0) ? 8'h5F
                               : 8'h41 + 8'($urandom_range(5));
            start_game(w);
            for (int k = 0; k < 60 && !mwin && !mlose; k++) begin
                if (mwin || mlose) break;
                if ($urandom_range(9) == 0)
                    g = 8'h30 + 8'($urandom_range(9));
                else
                    g = 8'h41 + 8'($urandom_range(9));
                do_guess(g);
                if (mwin || mlose) end_handoff();
            end
            if (rec_ready) begin
                rec_ready = 0;
                tick();
                tick();
                model_clear();
                check("rand_abort_disp", disp_word, mdisp());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/host_guess_checker.md
# host_guess_checker

Host-side game engine for wireless hangman. It sits directly downstream of the host message register. When `rec_ready` rises, it latches the 5-letter secret word and accepts ASCII guesses from the player link. For each guess it scans the word one position per cycle, then updates the revealed-letter display and the mistake count. At win or loss it holds the result and pulses `gameEnd_host` back to the message register to start a new round.

## Interface
- `MAX_MISTAKES`, default 6: wrong guesses that end the game; legal range 1–15.
- `END_HOLD`, default 12_000_000: cycles the win/lose result is held before `gameEnd_host`; minimum 1.
- `clk` in 1: system clock.
- `nRst` in 1: reset, asynchronous, active-low.
- `rec_ready` in 1: level from the message register; high while the word is final.
- `temp_word` in 40: secret word; byte [39:32] is position 0 (leftmost), [7:0] is position 4.
- `guess` in 8: ASCII guess letter.
- `guess_valid` in 1: one-cycle strobe qualifying `guess`.
- `disp_word` out 40: revealed letters; unrevealed positions show 0x5F (`_`).
- `mistakes` out 4: wrong-guess count.
- `guess_done` out 1: one-cycle pulse when a guess has been processed.
- `guess_hit` out 1: valid with `guess_done`; 1 if the guess matched at least one position.
- `win` out 1: level, high in END after a win.
- `lose` out 1: level, high in END after a loss.
- `busy` out 1: high in SCAN and UPDATE.
- `gameEnd_host` out 1: one-cycle pulse back to the message register.

## Operation
- States: IDLE, WAIT_GUESS, SCAN, UPDATE, END.
- IDLE:
  - Registers `rec_ready` as `rr_q`.
  - On `rec_ready & ~rr_q` (rising edge only), latch `temp_word` and clear `mistakes` and the used-letter mask.
  - Set the reveal mask bit for each position holding 0x5F; those positions were never set by the host.
  - If all 5 mask bits are set, go to END with `win`=1. Otherwise go to WAIT_GUESS.
- WAIT_GUESS:
  - A `guess` in 0x41–0x5A with `guess_valid`=1 is latched; set idx=0, hit=0 and go to SCAN.
  - A `guess` outside 0x41–0x5A is ignored: no state change, no `guess_done`.
- SCAN: compare word byte[idx] with the guess; on match set hit and match-mask bit[idx]. idx counts 0 to 4, then go to UPDATE.
- UPDATE:
  - Repeat guess (used-mask bit already set): treatment depends on `REPEAT_PENALTY_EN`; see Configuration.
  - New guess: set its used bit. If hit=1, OR the match mask into the reveal mask. If hit=0, increment `mistakes`.
  - Pulse `guess_done`, with `guess_hit` equal to hit.
  - If the reveal mask is all ones, go to END with `win`=1.
  - Else if `mistakes` equals `MAX_MISTAKES`, go to END with `lose`=1.
  - Else go to WAIT_GUESS.
- END:
  - Hold counter counts `END_HOLD` cycles, then pulse `gameEnd_host` and go to IDLE.
  - `win` and `lose` clear on entering IDLE.
  - `disp_word` holds its value until the next load.
  - On a win, `disp_word` equals `temp_word`. On a loss, it keeps the partial reveal.
- `disp_word` byte i equals the latched byte i if reveal bit i is set, else 0x5F.
- `rec_ready` falling in WAIT_GUESS, SCAN or UPDATE aborts to IDLE:
  - `disp_word` returns to all 0x5F and `mistakes` returns to 0.
  - No `guess_done` and no `gameEnd_host` is produced.
- `rec_ready` low in END is ignored.
- `guess_valid` outside WAIT_GUESS is dropped; there is no buffering.
- After a `gameEnd_host` pulse, `rec_ready` is still high in the same cycle (the message register drops it one cycle later). The rising-edge rule prevents a reload from this; a new game needs `rec_ready` to go low, then high.

## Timing
- Reset values:
  - State IDLE; `rr_q`=0.
  - `disp_word` = 0x5F5F5F5F5F; `mistakes`=0.
  - `guess_done`, `guess_hit`, `win`, `lose`, `busy`, `gameEnd_host` all 0.
- An asynchronous reset mid-game returns every register to these values immediately.
- Load: the clock edge that samples the `rec_ready` rise is E0. State becomes WAIT_GUESS (or END) at E0.
- Guess latency, with E0 as the edge sampling `guess_valid`:
  - SCAN occupies E1–E5.
  - `disp_word`, `mistakes`, `guess_done`, `guess_hit`, `win` and `lose` update at E6.
  - The next guess is accepted from E7.
- END entered at edge Ek: `gameEnd_host` is high for the one cycle after edge Ek+`END_HOLD`, and state is IDLE in that same cycle.
- All outputs are registered.

## Configuration
- `REPEAT_PENALTY_EN` defined: a repeat guess is scanned, then treated as a miss:
  - `mistakes` increments.
  - `guess_hit`=0.
  - The reveal mask is unchanged.
- `REPEAT_PENALTY_EN` undefined: a repeat guess still pulses `guess_done` with `guess_hit` equal to its scan result. `mistakes` and the reveal mask are unchanged.

## Test plan
- Load: reset, `temp_word`=48454C4C4F ("HELLO"), raise `rec_ready` -> state WAIT_GUESS; `disp_word`=5F5F5F5F5F; `mistakes`=0.
- Multi-hit: guess 0x4C -> 6 cycles later `guess_done`=1, `guess_hit`=1, `disp_word`=5F5F4C4C5F.
- Miss, then repeat: guess 0x5A -> `mistakes`=1. Guess 0x5A again:
  - Without the macro: `mistakes` stays 1.
  - With `REPEAT_PENALTY_EN`: `mistakes`=2.
  - Guess 0x31 -> no `guess_done`.
- Win, hand-off and re-arm (`END_HOLD`=4):
  - Guess H, E, O -> `win`=1 and `disp_word`=48454C4C4F.
  - 4 cycles later, a single `gameEnd_host` pulse.
  - With `rec_ready` held high, no reload occurs.
- Loss: `MAX_MISTAKES`=6, six distinct wrong letters -> `lose`=1, `mistakes`=6, and `guess_valid` is ignored in END.
- Partial word and abort:
  - `temp_word`=5F5F5F4142 -> `disp_word`=5F5F5F5F5F, with 2 letters needed to win.
  - Drop `rec_ready` mid-SCAN -> IDLE, `mistakes`=0, no `gameEnd_host`.
